// File: rtl/scope_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scope_pkg
// Purpose  : Shared definitions for the scope capture block: FSM state
//            encoding, trigger slope constants, the AC97 sample width and a
//            signed level/slope crossing helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package scope_pkg;

  localparam int SAMPLE_W = 16;

  // Capture FSM state encoding
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PREFILL   = 3'd1;
  localparam logic [2:0] WAIT_TRIG = 3'd2;
  localparam logic [2:0] POST      = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  // Trigger slope selection
  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  // True when the step prev -> cur crosses level in the selected direction.
  // All three operands are two's-complement samples.
  function automatic logic edgeHit(input logic [SAMPLE_W-1:0] prev,
                                   input logic [SAMPLE_W-1:0] cur,
                                   input logic [SAMPLE_W-1:0] level,
                                   input logic                slope);
    logic hit;
    if (slope == SLOPE_FALL)
      hit = ($signed(prev) > $signed(level)) && ($signed(cur) <= $signed(level));
    else
      hit = ($signed(prev) < $signed(level)) && ($signed(cur) >= $signed(level));
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scope_sample_ram.sv
`default_nettype none
// ============================================================================
// Module   : scope_sample_ram
// Purpose  : Simple dual-port sample memory, one write port and one read
//            port with a registered output (block-RAM style).
// Ports    : fclk      - clock
//            i_wrEn    - write enable
//            i_wrAddr  - write address
//            i_wrData  - write data
//            i_rdAddr  - read address
//            o_rdData  - read data, valid the cycle after i_rdAddr
// Revision : 1.0 - initial release
// ============================================================================
module scope_sample_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              fclk,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // No reset on the array or the output register so the tools can map
  // this onto a block RAM with its built-in output register.
  always_ff @(posedge fclk) begin
    if (i_wrEn)
      r_mem[i_wrAddr] <= i_wrData;
    o_rdData <= r_mem[i_rdAddr];
  end

endmodule
`default_nettype wire

// File: rtl/scope_capture.sv
`default_nettype none
// ============================================================================
// Module   : scope_capture
// Purpose  : Decimates one channel of the AC97 line-in stream, detects a
//            level/slope (or timeout) trigger and captures a window of
//            2^ADDR_W samples around it, PRE_TRIG of them before the trigger,
//            into a circular RAM which is then frozen for readout.
// Ports    : fclk, freset       - clock, async active-high reset
//            s_valid/s_left/s_right - sample strobe and L/R samples
//            ch_sel, trig_level, trig_slope, auto_en, decim - configuration
//            arm                - start (or restart) a capture
//            busy, done, forced - capture status
//            rd_addr/rd_data    - logical window read port, 1-cycle latency
// Revision : 1.0 - initial release
// ============================================================================
module scope_capture
  import scope_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int PRE_TRIG     = 256,
  parameter int AUTO_TIMEOUT = 48000
) (
  input  logic                fclk,
  input  logic                freset,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  input  logic                ch_sel,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_slope,
  input  logic                auto_en,
  input  logic [7:0]          decim,
  input  logic                arm,
  output logic                busy,
  output logic                done,
  output logic                forced,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  localparam int c_DEPTH = 1 << ADDR_W;
  localparam int c_PRE_W = $clog2(PRE_TRIG + 1);
  localparam int c_TO_W  = $clog2(AUTO_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0]  c_PRE_OFS   = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0]  c_POST_LOAD = ADDR_W'(c_DEPTH - PRE_TRIG - 1);
  localparam logic [c_PRE_W-1:0] c_PRE_LAST  = c_PRE_W'(PRE_TRIG - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST   = c_TO_W'(AUTO_TIMEOUT - 1);

  logic [2:0]          r_state;
  logic [7:0]          r_decCnt;
  logic [ADDR_W-1:0]   r_wrPtr;
  logic [ADDR_W-1:0]   r_startAddr;
  logic [c_PRE_W-1:0]  r_preCnt;
  logic [ADDR_W-1:0]   r_postCnt;
  logic [c_TO_W-1:0]   r_toCnt;
  logic [SAMPLE_W-1:0] r_prev;
  logic                r_prevValid;
  logic                r_forced;
  logic                r_rdValid;

  logic [SAMPLE_W-1:0] w_cur;
  logic                w_busy;
  logic                w_decHit;
  logic                w_accept;
  logic                w_edge;
  logic                w_timeout;
  logic                w_trig;
  logic [ADDR_W-1:0]   w_rdPhys;
  logic [SAMPLE_W-1:0] w_ramQ;

  assign w_cur    = ch_sel ? s_right : s_left;
  assign w_busy   = (r_state == PREFILL) || (r_state == WAIT_TRIG) || (r_state == POST);
  assign w_decHit = (r_decCnt == decim);
  // arm has priority: a strobe on the arm cycle is neither counted nor written
  assign w_accept = s_valid && !arm && w_busy && w_decHit;

  assign w_edge    = r_prevValid && edgeHit(r_prev, w_cur, trig_level, trig_slope);
  assign w_timeout = auto_en && (r_toCnt == c_TO_LAST);
  assign w_trig    = w_accept && (r_state == WAIT_TRIG) && (w_edge || w_timeout);

  always_ff @(posedge fclk or posedge freset) begin
    if (freset) begin
      r_state     <= IDLE;
      r_decCnt    <= '0;
      r_wrPtr     <= '0;
      r_startAddr <= '0;
      r_preCnt    <= '0;
      r_postCnt   <= '0;
      r_toCnt     <= '0;
      r_prev      <= '0;
      r_prevValid <= 1'b0;
      r_forced    <= 1'b0;
      r_rdValid   <= 1'b0;
    end else begin
      r_rdValid <= 1'b1;
      if (arm) begin
        // wr_ptr deliberately keeps running across re-arms
        r_state     <= PREFILL;
        r_preCnt    <= '0;
        r_decCnt    <= '0;
        r_toCnt     <= '0;
        r_prevValid <= 1'b0;
        r_forced    <= 1'b0;
      end else begin
        if (s_valid && w_busy)
          r_decCnt <= w_decHit ? 8'd0 : r_decCnt + 8'd1;

        if (w_accept) begin
          r_wrPtr     <= r_wrPtr + ADDR_W'(1);
          r_prev      <= w_cur;
          r_prevValid <= 1'b1;
          case (r_state)
            PREFILL: begin
              r_preCnt <= r_preCnt + c_PRE_W'(1);
              if (r_preCnt == c_PRE_LAST)
                r_state <= WAIT_TRIG;
            end
            WAIT_TRIG: begin
              if (w_trig) begin
                // The sample being written now is the trigger sample, so the
                // window begins PRE_TRIG words behind the current write slot.
                r_startAddr <= r_wrPtr - c_PRE_OFS;
                r_postCnt   <= c_POST_LOAD;
                r_forced    <= !w_edge;
                r_state     <= POST;
              end else begin
                r_toCnt <= r_toCnt + c_TO_W'(1);
              end
            end
            POST: begin
              r_postCnt <= r_postCnt - ADDR_W'(1);
              if (r_postCnt == ADDR_W'(1))
                r_state <= DONE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign w_rdPhys = r_startAddr + rd_addr;

  scope_sample_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (SAMPLE_W)
  ) u_ram (
    .fclk     (fclk),
    .i_wrEn   (w_accept),
    .i_wrAddr (r_wrPtr),
    .i_wrData (w_cur),
    .i_rdAddr (w_rdPhys),
    .o_rdData (w_ramQ)
  );

  // The RAM output register has no reset; hold rd_data at zero until the
  // first read after reset has been clocked through.
  assign rd_data = r_rdValid ? w_ramQ : '0;
  assign busy    = w_busy;
  assign done    = (r_state == DONE);
  assign forced  = r_forced;

endmodule
`default_nettype wire

// File: tb/tb_scope_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_scope_capture
// Purpose  : Self-checking bench for scope_capture. A queue-based model
//            records every accepted sample since arm, finds the trigger
//            index by scanning that history and predicts status and the
//            frozen window; a per-cycle process compares status outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scope_capture;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int PRE    = 256;
  localparam int TO     = 64;

  logic              fclk;
  logic              freset;
  logic              s_valid;
  logic [15:0]       s_left;
  logic [15:0]       s_right;
  logic              ch_sel;
  logic [15:0]       trig_level;
  logic              trig_slope;
  logic              auto_en;
  logic [7:0]        decim;
  logic              arm;
  logic              busy;
  logic              done;
  logic              forced;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  shortint acc[$];
  int      strobes  = 0;
  int      trigIdx  = -1;
  bit      mBusy    = 1'b0;
  bit      mDone    = 1'b0;
  bit      mForced  = 1'b0;

  scope_capture #(
    .ADDR_W       (ADDR_W),
    .PRE_TRIG     (PRE),
    .AUTO_TIMEOUT (TO)
  ) dut (
    .fclk       (fclk),
    .freset     (freset),
    .s_valid    (s_valid),
    .s_left     (s_left),
    .s_right    (s_right),
    .ch_sel     (ch_sel),
    .trig_level (trig_level),
    .trig_slope (trig_slope),
    .auto_en    (auto_en),
    .decim      (decim),
    .arm        (arm),
    .busy       (busy),
    .done       (done),
    .forced     (forced),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  task automatic modelClear(input bit armed);
    acc.delete();
    strobes = 0;
    trigIdx = -1;
    mBusy   = armed;
    mDone   = 1'b0;
    mForced = 1'b0;
  endtask

  // One strobe seen while capturing: keep every (decim+1)-th, then decide the
  // trigger from the stored history alone.
  task automatic modelStrobe();
    shortint cur, lvl;
    int      i;
    bit      hit;
    if (strobes % (int'(decim) + 1) == int'(decim)) begin
      cur = ch_sel ? shortint'(s_right) : shortint'(s_left);
      lvl = shortint'(trig_level);
      acc.push_back(cur);
      i = acc.size() - 1;
      if (trigIdx < 0 && i >= PRE) begin
        if (trig_slope) hit = (acc[i-1] > lvl) && (cur <= lvl);
        else            hit = (acc[i-1] < lvl) && (cur >= lvl);
        if (hit) trigIdx = i;
        else if (auto_en && (i - PRE == TO - 1)) begin
          trigIdx = i;
          mForced = 1'b1;
        end
      end
      if (trigIdx >= 0 && i == trigIdx + DEPTH - PRE - 1) begin
        mBusy = 1'b0;
        mDone = 1'b1;
      end
    end
    strobes++;
  endtask

  initial begin
    forever begin
      @(posedge fclk or posedge freset);
      if (freset)                modelClear(1'b0);
      else if (arm)              modelClear(1'b1);
      else if (mBusy && s_valid) modelStrobe();
    end
  end

  // Status compare on every falling edge outside reset
  initial begin
    forever begin
      @(negedge fclk);
      if (!freset) begin
        chk("busy",   int'(busy),   int'(mBusy));
        chk("done",   int'(done),   int'(mDone));
        chk("forced", int'(forced), int'(mForced));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  task automatic gen(input int mode, input int base, input int k,
                     output shortint l, output shortint r);
    l = shortint'(rnd(-1000, 1000));
    r = shortint'(rnd(-1000, 1000));
    case (mode)
      0: l = shortint'(base + k);
      1: r = shortint'($rtoi(1000.0 * $sin(6.283185307179586 * real'(k) / 97.0)));
      2: l = shortint'(base);
      default: ;
    endcase
  endtask

  task automatic feed(input int mode, input int base, input int k);
    shortint l, r;
    gen(mode, base, k, l, r);
    @(negedge fclk);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    if ($urandom_range(0, 3) == 0) begin
      @(negedge fclk);
      s_valid = 1'b0;
      s_left  = 16'($urandom);
      s_right = 16'($urandom);
    end
  endtask

  task automatic idle();
    @(negedge fclk);
    s_valid = 1'b0;
  endtask

  task automatic armWith(input bit ch, input int lvl, input bit slope,
                         input bit aut, input int dec, input bit withValid);
    @(negedge fclk);
    ch_sel     = ch;
    trig_level = 16'(lvl);
    trig_slope = slope;
    auto_en    = aut;
    decim      = 8'(dec);
    arm        = 1'b1;
    s_valid    = withValid;
    @(negedge fclk);
    arm     = 1'b0;
    s_valid = 1'b0;
  endtask

  // Feed until the model reaches DONE (or POST when untilPost), bounded
  task automatic runCapture(input int mode, input int base, input int maxS,
                            input bit untilPost);
    int k;
    k = 0;
    while (k < maxS && (untilPost ? (trigIdx < 0) : !mDone)) begin
      feed(mode, base, k);
      k++;
    end
    idle();
    if (untilPost) chk("reached_post_busy", int'(busy), 1);
    else           chk("reached_done", int'(done), 1);
  endtask

  task automatic readAt(input int a, output shortint v);
    @(negedge fclk);
    rd_addr = ADDR_W'(a);
    @(negedge fclk);
    v = shortint'(rd_data);
  endtask

  task automatic checkWindow(input string nm, input int step);
    shortint v, pv;
    pv = 0;
    if (mDone) begin
      for (int j = 0; j < DEPTH; j++) begin
        readAt(j, v);
        chk(nm, int'(v), int'(acc[trigIdx - PRE + j]));
        if (step != 0 && j > 0) chk("decim_step", int'(v) - int'(pv), step);
        pv = v;
      end
    end
  endtask

  initial begin
    shortint v;
    freset = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0; ch_sel = 1'b0;
    trig_level = '0; trig_slope = 1'b0; auto_en = 1'b0; decim = '0;
    arm = 1'b0; rd_addr = '0;

    // Reset state
    #1 freset = 1'b1;
    #1;
    chk("reset_busy",   int'(busy),   0);
    chk("reset_done",   int'(done),   0);
    chk("reset_forced", int'(forced), 0);
    chk("reset_rddata", int'(rd_data), 0);
    repeat (3) @(negedge fclk);
    freset = 1'b0;

    // IDLE ignores strobes
    for (int k = 0; k < 20; k++) feed(3, 0, k);
    idle();
    chk("idle_busy", int'(busy), 0);

    // Rising trigger on a left ramp
    armWith(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    runCapture(0, -2000, 3500, 1'b0);
    chk("model_rise_trig", trigIdx, 2000);
    readAt(256, v);  chk("rise_rd256",  int'(v), 0);
    readAt(0, v);    chk("rise_rd0",    int'(v), -256);
    readAt(1023, v); chk("rise_rd1023", int'(v), 767);
    chk("rise_forced", int'(forced), 0);
    checkWindow("rise_window", 0);

    // Falling trigger on a right-channel sine, left is noise
    armWith(1'b1, 100, 1'b1, 1'b0, 0, 1'b0);
    runCapture(1, 0, 3000, 1'b0);
    readAt(256, v); chk("fall_trig_le_level",  int'(v <= 16'sd100), 1);
    readAt(255, v); chk("fall_prev_gt_level",  int'(v > 16'sd100), 1);
    checkWindow("fall_window", 0);

    // Decimation by 4
    armWith(1'b0, 0, 1'b0, 1'b0, 3, 1'b0);
    runCapture(0, -1500, 6000, 1'b0);
    chk("model_decim_trigval", int'(acc[trigIdx]), 3);
    checkWindow("decim_window", 4);

    // Forced trigger after the timeout
    armWith(1'b0, 0, 1'b0, 1'b1, 0, 1'b0);
    runCapture(2, 500, 1300, 1'b0);
    chk("auto_forced", int'(forced), 1);
    chk("model_auto_count", acc.size(), 1087);
    chk("model_auto_trig", trigIdx, 319);
    checkWindow("auto_window", 0);

    // Without auto_en a flat input never completes
    armWith(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 1200; k++) feed(2, 500, k);
    idle();
    chk("noauto_busy", int'(busy), 1);
    chk("noauto_done", int'(done), 0);

    // Re-arm during POST of a forced capture, with a strobe on the arm cycle
    armWith(1'b0, 0, 1'b0, 1'b1, 0, 1'b0);
    runCapture(2, 7777, 1000, 1'b1);
    for (int k = 0; k < 100; k++) feed(2, 7777, k);
    idle();
    chk("rearm_pre_forced", int'(forced), 1);
    armWith(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    @(negedge fclk);
    chk("rearm_busy",   int'(busy),   1);
    chk("rearm_done",   int'(done),   0);
    chk("rearm_forced", int'(forced), 0);
    runCapture(0, -2000, 3500, 1'b0);
    readAt(256, v); chk("rearm_rd256", int'(v), 0);
    checkWindow("rearm_window", 0);

    // Asynchronous reset in the middle of POST
    armWith(1'(rnd(0, 1)), rnd(-200, 200), 1'(rnd(0, 1)), 1'b1, 0, 1'b0);
    runCapture(3, 0, 1000, 1'b1);
    for (int k = 0; k < 50; k++) feed(3, 0, k);
    idle();
    #2 freset = 1'b1;
    #1;
    chk("rst_busy",   int'(busy),    0);
    chk("rst_done",   int'(done),    0);
    chk("rst_forced", int'(forced),  0);
    chk("rst_rddata", int'(rd_data), 0);
    repeat (3) @(negedge fclk);
    freset = 1'b0;
    for (int k = 0; k < 30; k++) feed(3, 0, k);
    idle();
    chk("post_rst_idle_busy", int'(busy), 0);

    // Randomized captures
    for (int t = 0; t < 3; t++) begin
      armWith(1'(rnd(0, 1)), rnd(-200, 200), 1'(rnd(0, 1)), 1'b1, rnd(0, 1), 1'b0);
      runCapture(3, 0, 3000, 1'b0);
      checkWindow("rand_window", 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
